// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. A granted byte is registered onto tx_data with a one-cycle
// tx_start pulse; the arbiter then waits for tx_done_flag (or a watchdog
// expiry), optionally idles GAP_CYCLES clocks, and grants again.
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        allows new grants; an in-flight byte always completes
//   req_valid     per-requester byte-present flags
//   req_data      requester i byte on [8i+7:8i]
//   req_ack       one-hot, one-cycle capture pulse
//   tx_start      one-cycle start pulse to the transmitter
//   tx_data       byte to the transmitter, held until the next grant
//   tx_done_flag  completion pulse from the transmitter
//   grant_id      index of current / last granted requester
//   busy          high whenever the FSM is not idle
//   timeout_err   one-cycle pulse when the watchdog aborts a transfer

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done_flag,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitDone,
        StGap
    } state_e;

    localparam logic [15:0]     TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    state_e               r_state;
    logic [15:0]          r_wdog;
    logic [15:0]          r_gap;
    logic [ID_W-1:0]      r_last_grant;
    logic [NUM_REQ-1:0]   r_req_ack;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic [ID_W-1:0]      r_grant_id;
    logic                 r_timeout_err;

    state_e               w_state_nx;
    state_e               w_after_xfer;
    logic [15:0]          w_wdog_nx;
    logic [15:0]          w_gap_nx;
    logic [ID_W-1:0]      w_last_nx;
    logic [NUM_REQ-1:0]   w_ack_nx;
    logic                 w_start_nx;
    logic [7:0]           w_data_nx;
    logic [ID_W-1:0]      w_gid_nx;
    logic                 w_terr_nx;

    logic                 w_found_hi;
    logic [ID_W-1:0]      w_win_hi;
    logic [ID_W-1:0]      w_win_lo;
    logic [7:0]           w_data_hi;
    logic [7:0]           w_data_lo;
    logic [ID_W-1:0]      w_winner;
    logic [7:0]           w_win_data;
    logic [NUM_REQ-1:0]   w_win_oh;

    // Round-robin pick: the lowest valid index above last_grant wins; if there
    // is none, the lowest valid index at or below it. Scanning downward lets
    // the last hit in each half be the lowest index.
    always_comb begin
        w_found_hi = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_data_hi  = '0;
        w_data_lo  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(r_last_grant)) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = ID_W'(i);
                    w_data_hi  = req_data[8*i +: 8];
                end else begin
                    w_win_lo   = ID_W'(i);
                    w_data_lo  = req_data[8*i +: 8];
                end
            end
        end
        w_winner   = w_found_hi ? w_win_hi : w_win_lo;
        w_win_data = w_found_hi ? w_data_hi : w_data_lo;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_win_oh[i] = (ID_W'(i) == w_winner);
        end
    end

    assign w_after_xfer = (GAP_CYCLES == 0) ? StIdle : StGap;

    always_comb begin
        w_state_nx = r_state;
        w_wdog_nx  = r_wdog;
        w_gap_nx   = r_gap;
        w_last_nx  = r_last_grant;
        w_ack_nx   = '0;
        w_start_nx = 1'b0;
        w_data_nx  = r_tx_data;
        w_gid_nx   = r_grant_id;
        w_terr_nx  = 1'b0;
        case (r_state)
            StIdle: begin
                if (enable && (|req_valid)) begin
                    w_ack_nx   = w_win_oh;
                    w_start_nx = 1'b1;
                    w_data_nx  = w_win_data;
                    w_gid_nx   = w_winner;
                    w_last_nx  = w_winner;
                    w_wdog_nx  = '0;
                    w_state_nx = StWaitDone;
                end
            end
            StWaitDone: begin
                // Done takes precedence over a watchdog expiry on the same edge.
                if (tx_done_flag) begin
                    w_state_nx = w_after_xfer;
                    w_gap_nx   = '0;
                end else if (r_wdog == TO_LAST) begin
                    w_terr_nx  = 1'b1;
                    w_state_nx = w_after_xfer;
                    w_gap_nx   = '0;
                end else begin
                    w_wdog_nx  = r_wdog + 16'd1;
                end
            end
            StGap: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nx = StIdle;
                end else begin
                    w_gap_nx   = r_gap + 16'd1;
                end
            end
            default: begin
                w_state_nx = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_wdog        <= '0;
            r_gap         <= '0;
            r_last_grant  <= LAST_INIT;
            r_req_ack     <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_wdog        <= w_wdog_nx;
            r_gap         <= w_gap_nx;
            r_last_grant  <= w_last_nx;
            r_req_ack     <= w_ack_nx;
            r_tx_start    <= w_start_nx;
            r_tx_data     <= w_data_nx;
            r_grant_id    <= w_gid_nx;
            r_timeout_err <= w_terr_nx;
        end
    end

    assign req_ack     = r_req_ack;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != StIdle);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Instance A uses default timing (no gap,
// 2048-cycle watchdog); instance B uses a 5-cycle gap and a 16-cycle watchdog.
// Inputs are driven 1 ns after a rising edge and outputs sampled 1 ns after
// the next rising edge.

module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A: GAP_CYCLES = 0, TIMEOUT_CYCLES = 2048
    logic        a_rst_n, a_en, a_done;
    logic [3:0]  a_valid;
    logic [31:0] a_data;
    logic [3:0]  a_ack;
    logic        a_start, a_busy, a_terr;
    logic [7:0]  a_txd;
    logic [1:0]  a_gid;

    // Instance B: GAP_CYCLES = 5, TIMEOUT_CYCLES = 16
    logic        b_rst_n, b_en, b_done;
    logic [3:0]  b_valid;
    logic [31:0] b_data;
    logic [3:0]  b_ack;
    logic        b_start, b_busy, b_terr;
    logic [7:0]  b_txd;
    logic [1:0]  b_gid;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .ID_W          (2),
        .GAP_CYCLES    (0),
        .TIMEOUT_CYCLES(2048)
    ) u_dut_a (
        .clk_in      (clk),
        .rst_n       (a_rst_n),
        .enable      (a_en),
        .req_valid   (a_valid),
        .req_data    (a_data),
        .req_ack     (a_ack),
        .tx_start    (a_start),
        .tx_data     (a_txd),
        .tx_done_flag(a_done),
        .grant_id    (a_gid),
        .busy        (a_busy),
        .timeout_err (a_terr)
    );

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .ID_W          (2),
        .GAP_CYCLES    (5),
        .TIMEOUT_CYCLES(16)
    ) u_dut_b (
        .clk_in      (clk),
        .rst_n       (b_rst_n),
        .enable      (b_en),
        .req_valid   (b_valid),
        .req_data    (b_data),
        .req_ack     (b_ack),
        .tx_start    (b_start),
        .tx_data     (b_txd),
        .tx_done_flag(b_done),
        .grant_id    (b_gid),
        .busy        (b_busy),
        .timeout_err (b_terr)
    );

    // Output bundle: {ack[3:0], start, data[7:0], gid[1:0], busy, timeout_err}
    function automatic logic [16:0] a_out();
        return {a_ack, a_start, a_txd, a_gid, a_busy, a_terr};
    endfunction

    function automatic logic [16:0] b_out();
        return {b_ack, b_start, b_txd, b_gid, b_busy, b_terr};
    endfunction

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        done;
        logic [16:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [3:0] valid,
                                input logic [31:0] data, input logic done,
                                input logic [3:0] ack, input logic start,
                                input logic [7:0] txd, input logic [1:0] gid,
                                input logic bsy, input logic terr);
        vec_t v;
        v.en    = en;
        v.valid = valid;
        v.data  = data;
        v.done  = done;
        v.exp   = {ack, start, txd, gid, bsy, terr};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_a();
        a_rst_n = 1'b0;
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
    endtask

    task automatic wait_start_a(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick(1);
            n++;
            if (a_start) ok = 1'b1;
        end
    endtask

    task automatic wait_start_b(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick(1);
            n++;
            if (b_start) ok = 1'b1;
        end
    endtask

    task automatic wait_terr_b(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick(1);
            n++;
            if (b_terr) ok = 1'b1;
        end
    endtask

    localparam logic [31:0] D0 = 32'h13121110;
    localparam logic [31:0] D1 = 32'hDDCCBBAA;

    vec_t        vecs[16];
    bit          ok;
    bit          seen;
    int unsigned t_prev, t_mark;
    logic [7:0]  exp_byte;

    initial begin
        // Cycle-by-cycle vectors for instance A starting from reset (last_grant = 3).
        vecs[0]  = mk(1'b0, 4'b0010, D0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 4'b0010, D0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 4'b0010, D0, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 4'b0000, D0, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd1, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 4'b1001, D0, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 4'b1001, D0, 1'b0, 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 4'b0001, D0, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 4'b0001, D0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 4'b0001, D0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 4'b0001, D0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 4'b0001, D0, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 4'b0001, D0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 4'b0001, D0, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 4'b0101, D1, 1'b0, 4'b0100, 1'b1, 8'hCC, 2'd2, 1'b1, 1'b0);
        vecs[14] = mk(1'b1, 4'b0000, D1, 1'b1, 4'b0000, 1'b0, 8'hCC, 2'd2, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, 4'b0000, D1, 1'b1, 4'b0000, 1'b0, 8'hCC, 2'd2, 1'b0, 1'b0);

        a_rst_n = 1'b0; a_en = 1'b0; a_valid = '0; a_data = '0; a_done = 1'b0;
        b_rst_n = 1'b0; b_en = 1'b0; b_valid = '0; b_data = '0; b_done = 1'b0;
        #1;
        chk("a_reset_outputs", 64'(a_out()), 64'(17'd0));
        chk("b_reset_outputs", 64'(b_out()), 64'(17'd0));
        tick(2);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            a_en    = vecs[i].en;
            a_valid = vecs[i].valid;
            a_data  = vecs[i].data;
            a_done  = vecs[i].done;
            tick(1);
            chk($sformatf("vec%0d", i), 64'(a_out()), 64'(vecs[i].exp));
        end
        a_done = 1'b0;

        // Single requester: req 2 with 0xA5, done sampled 101 edges after the grant edge.
        a_en = 1'b0; a_valid = '0;
        reset_a();
        a_en = 1'b1; a_valid = 4'b0100; a_data = 32'h00A50000;
        tick(1);
        chk("single_grant", 64'(a_out()), 64'({4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0}));
        a_valid = '0;
        tick(1);
        chk("single_pulse_width", 64'({a_ack, a_start, a_busy}), 64'({4'b0000, 1'b0, 1'b1}));
        tick(99);
        chk("single_busy_before_done", 64'(a_busy), 64'(1'b1));
        a_done = 1'b1;
        tick(1);
        a_done = 1'b0;
        chk("single_idle_after_done", 64'({a_busy, a_txd, a_gid}), 64'({1'b0, 8'hA5, 2'd2}));

        // Round robin: all four continuously valid, done 20 cycles after each start.
        reset_a();
        a_en = 1'b1; a_valid = 4'b1111; a_data = D0;
        t_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_start_a(40, ok);
            chk($sformatf("rr_start_seen%0d", g), 64'(ok), 64'(1'b1));
            exp_byte = 8'h10 + 8'(g % 4);
            chk($sformatf("rr_data%0d", g), 64'(a_txd), 64'(exp_byte));
            if (g > 0) chk($sformatf("rr_spacing%0d", g), 64'(cyc - t_prev), 64'(22));
            t_prev = cyc;
            tick(20);
            a_done = 1'b1;
            tick(1);
            a_done = 1'b0;
        end

        // Enable gating, then reset in the middle of WAIT_DONE.
        a_en = 1'b0; a_valid = '0;
        reset_a();
        a_valid = 4'b0010; a_data = 32'h00005500;
        seen = 1'b0;
        repeat (50) begin
            tick(1);
            if (a_ack != 4'b0000 || a_start) seen = 1'b1;
        end
        chk("enable_low_no_ack", 64'(seen), 64'(1'b0));
        a_en = 1'b1;
        tick(1);
        chk("enable_high_grant", 64'({a_ack, a_start, a_gid, a_txd}),
            64'({4'b0010, 1'b1, 2'd1, 8'h55}));
        tick(3);
        chk("mid_wait_busy", 64'(a_busy), 64'(1'b1));
        a_rst_n = 1'b0;
        #1;
        chk("reset_mid_transfer", 64'(a_out()), 64'(17'd0));
        a_valid = 4'b0011; a_data = 32'h00006655;
        tick(1);
        a_rst_n = 1'b1;
        tick(1);
        chk("post_reset_grant", 64'({a_ack, a_gid, a_txd}), 64'({4'b0001, 2'd0, 8'h55}));

        // Instance B: gap after done.
        b_en = 1'b1; b_valid = 4'b0011; b_data = 32'h44332211;
        wait_start_b(10, ok);
        chk("gap_first_start", 64'(ok), 64'(1'b1));
        chk("gap_first_id", 64'({b_gid, b_txd}), 64'({2'd0, 8'h11}));
        tick(3);
        b_done = 1'b1;
        t_mark = cyc;
        tick(1);
        b_done = 1'b0;
        chk("gap_busy_in_gap", 64'(b_busy), 64'(1'b1));
        wait_start_b(20, ok);
        chk("gap_second_start", 64'(ok), 64'(1'b1));
        chk("gap_spacing", 64'(cyc - t_mark), 64'(7));
        chk("gap_second_id", 64'({b_gid, b_txd}), 64'({2'd1, 8'h22}));

        // Watchdog: no done for the requester-1 transfer.
        t_mark = cyc;
        wait_terr_b(40, ok);
        chk("wd_seen", 64'(ok), 64'(1'b1));
        chk("wd_delay", 64'(cyc - t_mark), 64'(16));
        t_mark = cyc;
        tick(1);
        chk("wd_pulse_width", 64'(b_terr), 64'(1'b0));
        wait_start_b(20, ok);
        chk("wd_regrant_seen", 64'(ok), 64'(1'b1));
        chk("wd_regrant_delay", 64'(cyc - t_mark), 64'(6));
        chk("wd_regrant_id", 64'({b_ack, b_gid, b_txd}), 64'({4'b0001, 2'd0, 8'h11}));

        // Done arriving on the same edge the watchdog would fire.
        b_valid = '0;
        tick(15);
        b_done = 1'b1;
        tick(1);
        b_done = 1'b0;
        chk("collision_no_terr", 64'({b_terr, b_busy}), 64'({1'b0, 1'b1}));
        seen = 1'b0;
        repeat (5) begin
            tick(1);
            if (b_terr) seen = 1'b1;
        end
        chk("collision_no_late_terr", 64'(seen), 64'(1'b0));
        chk("collision_idle_after_gap", 64'(b_busy), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
